// File: rtl/pipe_ctrl_nway_if.sv
// Handshake bundle between the pipeline control block and the rest of the core.
// The master drives requests and the slave (pipe_ctrl_nway) drives controls.
interface pipe_ctrl_nway_if #(
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int NSTAGE     = 5
);
    logic                        icache_stall_req;
    logic                        dcache_stall_req;
    logic                        hazard_stall_req;
    logic                        ex_stall_req;
    logic                        excp_flag;
    logic [ADDR_WIDTH-1:0]       excp_pc;
    logic [LANES-1:0]            br_flag;
    logic [LANES*ADDR_WIDTH-1:0] br_pc;
    logic [LANES-1:0]            fence_req;
    logic [LANES-1:0]            wfi_req;
    logic                        wfi_clr;
    logic [LANES-1:0]            ex_ldst;
    logic [LANES-1:0]            mem_ldst;
    logic                        mem_flush_done;
    logic                        redir_ready;

    logic [NSTAGE-1:0]           stall;
    logic [NSTAGE-2:0]           flush;
    logic [LANES-1:0]            lane_kill;
    logic                        redir_valid;
    logic [ADDR_WIDTH-1:0]       redir_pc;
    logic                        mem_flush;
    logic                        fence_busy;
    logic                        wfi_sleep;

    modport master (
        output icache_stall_req, dcache_stall_req, hazard_stall_req, ex_stall_req,
               excp_flag, excp_pc, br_flag, br_pc, fence_req, wfi_req, wfi_clr,
               ex_ldst, mem_ldst, mem_flush_done, redir_ready,
        input  stall, flush, lane_kill, redir_valid, redir_pc, mem_flush,
               fence_busy, wfi_sleep
    );

    modport slave (
        input  icache_stall_req, dcache_stall_req, hazard_stall_req, ex_stall_req,
               excp_flag, excp_pc, br_flag, br_pc, fence_req, wfi_req, wfi_clr,
               ex_ldst, mem_ldst, mem_flush_done, redir_ready,
        output stall, flush, lane_kill, redir_valid, redir_pc, mem_flush,
               fence_busy, wfi_sleep
    );
endinterface

// File: rtl/pipe_ctrl_nway.sv
// N-way pipeline control: stall/flush generation, branch/exception redirect,
// fence sequencing with dcache flush, and WFI sleep.
module pipe_ctrl_nway #(
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int NSTAGE     = 5
) (
    input logic            clk,
    input logic            rst_n,
    pipe_ctrl_nway_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] RESUME = 2'd3;

    logic [1:0]            fenceState;
    logic                  wfiSleep;
    logic                  redirValid;
    logic [ADDR_WIDTH-1:0] redirPc;
    logic                  memFlush;

    logic                  brFound;
    logic [ADDR_WIDTH-1:0] brTarget;
    logic [LANES-1:0]      killMask;
    logic [4:0]            stallBase;
    logic [NSTAGE-1:0]     stallVec;
    logic [NSTAGE-2:0]     flushVec;
    logic                  fenceStart;
    logic                  drainDone;
    logic                  wfiAccept;

    // Lane 0 is oldest: the first flagged lane wins and every younger lane dies.
    always_comb begin
        brFound  = 1'b0;
        brTarget = '0;
        killMask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (brFound) begin
                killMask[i] = 1'b1;
            end else if (bus.br_flag[i]) begin
                brFound  = 1'b1;
                brTarget = bus.br_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        if (wfiSleep)                                       stallBase = 5'b11111;
        else if (bus.dcache_stall_req)                      stallBase = 5'b00111;
        else if (fenceState == DRAIN || fenceState == FLUSH) stallBase = 5'b00011;
        else if (bus.hazard_stall_req)                      stallBase = 5'b00011;
        else if (bus.ex_stall_req)                          stallBase = 5'b00111;
        else if (bus.icache_stall_req)                      stallBase = 5'b00001;
        else if (redirValid && !bus.redir_ready)            stallBase = 5'b00001;
        else                                                stallBase = 5'b00000;
    end

    // Stages past WB-side index 4 track bit 4 when the pipe is deeper than five.
    always_comb begin
        stallVec = '0;
        for (int unsigned k = 0; k < NSTAGE; k++)
            stallVec[k] = stallBase[(k < 5) ? k : 4];
    end

    always_comb begin
        flushVec = '0;
        for (int unsigned k = 0; k < NSTAGE - 1; k++)
            flushVec[k] = (stallVec[k] & ~stallVec[k+1])
                        | (bus.excp_flag & (k < 3))
                        | (brFound & (k < 2))
                        | ((fenceState == RESUME) & (k == 0));
    end

    assign fenceStart = (fenceState == IDLE) && (|bus.fence_req) && !brFound && !bus.excp_flag;
    assign drainDone  = (bus.ex_ldst == '0) && (bus.mem_ldst == '0) && !bus.dcache_stall_req;
    assign wfiAccept  = (|bus.wfi_req) && !bus.excp_flag && !bus.wfi_clr
                     && (fenceState == IDLE) && !fenceStart;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirValid <= 1'b0;
            redirPc    <= '0;
        end else if (bus.excp_flag) begin
            redirValid <= 1'b1;
            redirPc    <= bus.excp_pc;
        end else if (redirValid) begin
            if (bus.redir_ready)
                redirValid <= 1'b0;
        end else if (brFound) begin
            redirValid <= 1'b1;
            redirPc    <= brTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fenceState <= IDLE;
            memFlush   <= 1'b0;
        end else begin
            memFlush <= 1'b0;
            if (bus.excp_flag) begin
                fenceState <= IDLE;
            end else begin
                case (fenceState)
                    IDLE:   if (fenceStart) fenceState <= DRAIN;
                    DRAIN:  if (drainDone) begin
                                fenceState <= FLUSH;
                                memFlush   <= 1'b1;
                            end
                    FLUSH:  if (bus.mem_flush_done) fenceState <= RESUME;
                    default: fenceState <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wfiSleep <= 1'b0;
        else if (wfiSleep)
            wfiSleep <= !bus.wfi_clr;
        else
            wfiSleep <= wfiAccept;
    end

    assign bus.stall       = stallVec;
    assign bus.flush       = flushVec;
    assign bus.lane_kill   = bus.excp_flag ? '1 : killMask;
    assign bus.redir_valid = redirValid;
    assign bus.redir_pc    = redirPc;
    assign bus.mem_flush   = memFlush;
    assign bus.fence_busy  = (fenceState != IDLE);
    assign bus.wfi_sleep   = wfiSleep;
endmodule

// File: tb/tb_pipe_ctrl_nway.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the pipeline control rules.
module tb_pipe_ctrl_nway;
    localparam int L  = 2;
    localparam int AW = 32;
    localparam int NS = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_nway_if #(.LANES(L), .ADDR_WIDTH(AW), .NSTAGE(NS)) bus ();

    pipe_ctrl_nway #(.LANES(L), .ADDR_WIDTH(AW), .NSTAGE(NS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus.icache_stall_req = 0; bus.dcache_stall_req = 0;
        bus.hazard_stall_req = 0; bus.ex_stall_req = 0;
        bus.excp_flag = 0; bus.excp_pc = '0;
        bus.br_flag = '0; bus.br_pc = '0;
        bus.fence_req = '0; bus.wfi_req = '0; bus.wfi_clr = 0;
        bus.ex_ldst = '0; bus.mem_ldst = '0;
        bus.mem_flush_done = 0; bus.redir_ready = 1;
    endtask

    task automatic test_reset();
        clearIn();
        rst_n = 0;
        step(); step();
        #2;
        total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL reset_redir_valid got %0h want 0", bus.redir_valid); end
        total++; if (bus.redir_pc !== 32'h0) begin bad++; $display("FAIL reset_redir_pc got %0h want 0", bus.redir_pc); end
        total++; if (bus.mem_flush !== 1'b0) begin bad++; $display("FAIL reset_mem_flush got %0h want 0", bus.mem_flush); end
        total++; if (bus.fence_busy !== 1'b0) begin bad++; $display("FAIL reset_fence_busy got %0h want 0", bus.fence_busy); end
        total++; if (bus.wfi_sleep !== 1'b0) begin bad++; $display("FAIL reset_wfi_sleep got %0h want 0", bus.wfi_sleep); end
        total++; if (bus.stall !== 5'b0) begin bad++; $display("FAIL reset_stall got %0h want 0", bus.stall); end
        rst_n = 1;
        step();
    endtask

    task automatic test_branch();
        clearIn();
        bus.br_flag = 2'b11; bus.br_pc = {32'h200, 32'h100};
        #2;
        total++; if (bus.lane_kill !== 2'b10) begin bad++; $display("FAIL br_lane_kill got %0h want 2", bus.lane_kill); end
        total++; if (bus.flush[1:0] !== 2'b11) begin bad++; $display("FAIL br_flush got %0h want 3", bus.flush[1:0]); end
        step();
        bus.br_flag = '0;
        #2;
        total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL br_redir_valid got %0h want 1", bus.redir_valid); end
        total++; if (bus.redir_pc !== 32'h100) begin bad++; $display("FAIL br_redir_pc got %0h want 100", bus.redir_pc); end
        step();
        #2;
        total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL br_redir_clear got %0h want 0", bus.redir_valid); end
        bus.br_flag = 2'b10; bus.br_pc = {32'h240, 32'h140};
        #1;
        total++; if (bus.lane_kill !== 2'b00) begin bad++; $display("FAIL br_lane1_kill got %0h want 0", bus.lane_kill); end
        step();
        bus.br_flag = '0;
        #2;
        total++; if (bus.redir_pc !== 32'h240) begin bad++; $display("FAIL br_lane1_pc got %0h want 240", bus.redir_pc); end
        step(); step();
    endtask

    task automatic test_redirect_hold();
        clearIn();
        bus.redir_ready = 0;
        bus.br_flag = 2'b01; bus.br_pc = {32'h0, 32'h300};
        step();
        bus.br_pc = {32'h0, 32'h400};
        #2;
        total++; if (bus.stall !== 5'b00001) begin bad++; $display("FAIL hold_stall_c1 got %0h want 1", bus.stall); end
        total++; if (bus.redir_pc !== 32'h300) begin bad++; $display("FAIL hold_pc_c1 got %0h want 300", bus.redir_pc); end
        step();
        bus.br_flag = '0; bus.excp_flag = 1; bus.excp_pc = 32'h80;
        #2;
        total++; if (bus.stall !== 5'b00001) begin bad++; $display("FAIL hold_stall_c2 got %0h want 1", bus.stall); end
        total++; if (bus.redir_pc !== 32'h300) begin bad++; $display("FAIL hold_br_ignored got %0h want 300", bus.redir_pc); end
        total++; if (bus.flush[2:0] !== 3'b111) begin bad++; $display("FAIL hold_excp_flush got %0h want 7", bus.flush[2:0]); end
        total++; if (bus.lane_kill !== 2'b11) begin bad++; $display("FAIL hold_excp_kill got %0h want 3", bus.lane_kill); end
        step();
        bus.excp_flag = 0;
        #2;
        total++; if (bus.stall !== 5'b00001) begin bad++; $display("FAIL hold_stall_c3 got %0h want 1", bus.stall); end
        total++; if (bus.redir_pc !== 32'h80) begin bad++; $display("FAIL hold_excp_pc got %0h want 80", bus.redir_pc); end
        step();
        bus.redir_ready = 1;
        #2;
        total++; if (bus.stall !== 5'b0) begin bad++; $display("FAIL hold_ready_stall got %0h want 0", bus.stall); end
        total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL hold_ready_valid got %0h want 1", bus.redir_valid); end
        step();
        #2;
        total++; if (bus.redir_valid !== 1'b0) begin bad++; $display("FAIL hold_cleared got %0h want 0", bus.redir_valid); end
        step();
    endtask

    task automatic test_fence();
        int pulses = 0;
        clearIn();
        bus.fence_req = 2'b01; bus.mem_ldst = 2'b01;
        #2;
        total++; if (bus.fence_busy !== 1'b0) begin bad++; $display("FAIL fence_idle_busy got %0h want 0", bus.fence_busy); end
        step();
        bus.fence_req = '0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.mem_ldst = '0;
            #2;
            total++; if (bus.stall !== 5'b00011) begin bad++; $display("FAIL fence_drain_stall c=%0d got %0h want 3", c, bus.stall); end
            total++; if (bus.fence_busy !== 1'b1) begin bad++; $display("FAIL fence_drain_busy c=%0d got %0h want 1", c, bus.fence_busy); end
            if (bus.mem_flush) pulses++;
            step();
        end
        for (int f = 0; f < 4; f++) begin
            bus.mem_flush_done = (f == 3);
            #2;
            total++; if (bus.stall !== 5'b00011) begin bad++; $display("FAIL fence_flush_stall f=%0d got %0h want 3", f, bus.stall); end
            total++; if (bus.mem_flush !== (f == 0)) begin bad++; $display("FAIL fence_pulse f=%0d got %0h want %0h", f, bus.mem_flush, (f == 0)); end
            if (bus.mem_flush) pulses++;
            step();
        end
        bus.mem_flush_done = 0;
        #2;
        total++; if (bus.flush !== 4'b0001) begin bad++; $display("FAIL fence_resume_flush got %0h want 1", bus.flush); end
        total++; if (bus.fence_busy !== 1'b1) begin bad++; $display("FAIL fence_resume_busy got %0h want 1", bus.fence_busy); end
        if (bus.mem_flush) pulses++;
        step();
        #2;
        total++; if (bus.fence_busy !== 1'b0) begin bad++; $display("FAIL fence_done_busy got %0h want 0", bus.fence_busy); end
        total++; if (pulses != 1) begin bad++; $display("FAIL fence_pulse_count got %0d want 1", pulses); end
        step();
    endtask

    task automatic test_wfi();
        clearIn();
        bus.wfi_req = 2'b10;
        step();
        bus.wfi_req = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 9) bus.wfi_clr = 1;
            #2;
            total++; if (bus.stall !== 5'b11111) begin bad++; $display("FAIL wfi_sleep_stall c=%0d got %0h want 1f", c, bus.stall); end
            total++; if (bus.wfi_sleep !== 1'b1) begin bad++; $display("FAIL wfi_sleep c=%0d got %0h want 1", c, bus.wfi_sleep); end
            step();
        end
        bus.wfi_clr = 0;
        #2;
        total++; if (bus.stall !== 5'b0) begin bad++; $display("FAIL wfi_wake_stall got %0h want 0", bus.stall); end
        total++; if (bus.wfi_sleep !== 1'b0) begin bad++; $display("FAIL wfi_wake got %0h want 0", bus.wfi_sleep); end
        bus.wfi_req = 2'b10; bus.wfi_clr = 1;
        step();
        bus.wfi_req = '0; bus.wfi_clr = 0;
        #2;
        total++; if (bus.wfi_sleep !== 1'b0) begin bad++; $display("FAIL wfi_same_cycle got %0h want 0", bus.wfi_sleep); end
        step();
    endtask

    task automatic test_dcache_reset();
        clearIn();
        bus.dcache_stall_req = 1; bus.hazard_stall_req = 1;
        #2;
        total++; if (bus.stall !== 5'b00111) begin bad++; $display("FAIL dc_hz_stall got %0h want 7", bus.stall); end
        total++; if (bus.flush !== 4'b0100) begin bad++; $display("FAIL dc_hz_flush got %0h want 4", bus.flush); end
        step();
        clearIn();
        bus.fence_req = 2'b01; bus.mem_ldst = 2'b01;
        step();
        bus.fence_req = '0;
        #2;
        total++; if (bus.fence_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got %0h want 1", bus.fence_busy); end
        bus.mem_ldst = '0;
        rst_n = 0;
        step();
        #2;
        total++; if (bus.fence_busy !== 1'b0) begin bad++; $display("FAIL rst_drain_busy got %0h want 0", bus.fence_busy); end
        total++; if (bus.mem_flush !== 1'b0) begin bad++; $display("FAIL rst_drain_flush got %0h want 0", bus.mem_flush); end
        rst_n = 1;
        step();
        #2;
        total++; if (bus.mem_flush !== 1'b0) begin bad++; $display("FAIL rst_after_flush got %0h want 0", bus.mem_flush); end
        total++; if (bus.fence_busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy got %0h want 0", bus.fence_busy); end
        step();
    endtask

    // Model state: fence phase 0..3 = idle/drain/flush/resume.
    task automatic test_random();
        int       phase = 0;
        bit       asleep = 0;
        bit       rv = 0;
        bit [31:0] rpc = 0;
        bit       mflush = 0;
        clearIn();
        rst_n = 0; step(); rst_n = 1; step();
        for (int n = 0; n < 600; n++) begin
            int        win;
            int        expStall;
            int        expKill;
            int        expFlush;
            int        nPhase;
            bit        nAsleep, nRv, nFlush, started;
            bit [31:0] nPc;
            bit [31:0] pcs [L];
            bus.icache_stall_req = ($urandom_range(7) == 0);
            bus.dcache_stall_req = ($urandom_range(7) == 0);
            bus.hazard_stall_req = ($urandom_range(7) == 0);
            bus.ex_stall_req     = ($urandom_range(7) == 0);
            bus.excp_flag        = ($urandom_range(15) == 0);
            bus.excp_pc          = $urandom;
            bus.br_flag          = ($urandom_range(3) == 0) ? L'($urandom) : '0;
            for (int i = 0; i < L; i++) begin
                pcs[i] = $urandom;
                bus.br_pc[i*AW +: AW] = pcs[i];
            end
            bus.fence_req      = ($urandom_range(5) == 0) ? L'($urandom_range(1, 3)) : '0;
            bus.wfi_req        = ($urandom_range(9) == 0) ? L'($urandom_range(1, 3)) : '0;
            bus.wfi_clr        = ($urandom_range(3) == 0);
            bus.ex_ldst        = ($urandom_range(2) == 0) ? L'($urandom) : '0;
            bus.mem_ldst       = ($urandom_range(2) == 0) ? L'($urandom) : '0;
            bus.mem_flush_done = ($urandom_range(2) == 0);
            bus.redir_ready    = ($urandom_range(1) == 0);
            #2;
            win = -1;
            for (int i = 0; i < L; i++) if (win < 0 && bus.br_flag[i]) win = i;
            if (bus.excp_flag) expKill = (1 << L) - 1;
            else if (win < 0)  expKill = 0;
            else               expKill = ((1 << L) - 1) & ~((2 << win) - 1);
            if (asleep)                          expStall = 31;
            else if (bus.dcache_stall_req)       expStall = 7;
            else if (phase == 1 || phase == 2)   expStall = 3;
            else if (bus.hazard_stall_req)       expStall = 3;
            else if (bus.ex_stall_req)           expStall = 7;
            else if (bus.icache_stall_req)       expStall = 1;
            else if (rv && !bus.redir_ready)     expStall = 1;
            else                                 expStall = 0;
            expFlush = 0;
            for (int k = 0; k < NS - 1; k++) begin
                bit b;
                b = ((expStall >> k) & 1) && !((expStall >> (k + 1)) & 1);
                b = b || (bus.excp_flag && k < 3) || (win >= 0 && k < 2) || (phase == 3 && k == 0);
                if (b) expFlush += (1 << k);
            end
            total++; if (bus.stall !== NS'(expStall)) begin bad++; $display("FAIL rnd_stall n=%0d got %0h want %0h", n, bus.stall, expStall); end
            total++; if (bus.flush !== (NS-1)'(expFlush)) begin bad++; $display("FAIL rnd_flush n=%0d got %0h want %0h", n, bus.flush, expFlush); end
            total++; if (bus.lane_kill !== L'(expKill)) begin bad++; $display("FAIL rnd_kill n=%0d got %0h want %0h", n, bus.lane_kill, expKill); end
            total++; if (bus.redir_valid !== rv) begin bad++; $display("FAIL rnd_rv n=%0d got %0h want %0h", n, bus.redir_valid, rv); end
            total++; if (bus.redir_pc !== rpc) begin bad++; $display("FAIL rnd_rpc n=%0d got %0h want %0h", n, bus.redir_pc, rpc); end
            total++; if (bus.mem_flush !== mflush) begin bad++; $display("FAIL rnd_mflush n=%0d got %0h want %0h", n, bus.mem_flush, mflush); end
            total++; if (bus.fence_busy !== (phase != 0)) begin bad++; $display("FAIL rnd_busy n=%0d got %0h want %0h", n, bus.fence_busy, phase != 0); end
            total++; if (bus.wfi_sleep !== asleep) begin bad++; $display("FAIL rnd_sleep n=%0d got %0h want %0h", n, bus.wfi_sleep, asleep); end
            nRv = rv; nPc = rpc;
            if (bus.excp_flag) begin nRv = 1; nPc = bus.excp_pc; end
            else if (rv) begin if (bus.redir_ready) nRv = 0; end
            else if (win >= 0) begin nRv = 1; nPc = pcs[win]; end
            started = (phase == 0) && (bus.fence_req != 0) && (win < 0) && !bus.excp_flag;
            nFlush = 0;
            nPhase = phase;
            if (bus.excp_flag) nPhase = 0;
            else if (started) nPhase = 1;
            else if (phase == 1 && bus.ex_ldst == 0 && bus.mem_ldst == 0 && !bus.dcache_stall_req) begin
                nPhase = 2; nFlush = 1;
            end
            else if (phase == 2 && bus.mem_flush_done) nPhase = 3;
            else if (phase == 3) nPhase = 0;
            if (asleep) nAsleep = !bus.wfi_clr;
            else nAsleep = (bus.wfi_req != 0) && !bus.excp_flag && !bus.wfi_clr && phase == 0 && !started;
            step();
            rv = nRv; rpc = nPc; phase = nPhase; mflush = nFlush; asleep = nAsleep;
        end
    endtask

    initial begin
        clearIn();
        test_reset();
        test_branch();
        test_redirect_hold();
        test_fence();
        test_wfi();
        test_dcache_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
